memory_access_unit: RTL

//  Memory stage of the BRISC-V pipeline: feeds memory_pipe_unit's load_data_memory input.
//  - Issues load/store requests to data memory over a valid/ready bus and aligns stores into byte lanes.
//  - Aligns and sign/zero-extends load data.
//  - Stalls the pipeline via memory_stall until each access completes.

---
 rtl/memory_access_unit_if.sv | 26 ++
 rtl/memory_access_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/memory_access_unit_if.sv
// Data-memory bus between the memory stage and data memory.
// The master side issues valid/ready requests with lane enables and store data.
// The slave side answers loads with a later response strobe and the raw word.
interface memory_access_unit_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
);
  logic                    dmem_req_valid;
  logic                    dmem_req_ready;
  logic                    dmem_we;
  logic [3:0]              dmem_byte_en;
  logic [ADDRESS_BITS-1:0] dmem_address;
  logic [DATA_WIDTH-1:0]   dmem_wdata;
  logic                    dmem_resp_valid;
  logic [DATA_WIDTH-1:0]   dmem_rdata;

  modport master (
    output dmem_req_valid, dmem_we, dmem_byte_en, dmem_address, dmem_wdata,
    input  dmem_req_ready, dmem_resp_valid, dmem_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_we, dmem_byte_en, dmem_address, dmem_wdata,
    output dmem_req_ready, dmem_resp_valid, dmem_rdata
  );
endinterface

// File: rtl/memory_access_unit.sv
// Memory stage of the BRISC-V pipeline.
// Issues loads/stores on the data-memory bus, places store data into byte lanes,
// aligns and extends load data, and stalls the pipeline until each access is done.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned halfword/word
// accesses instead of issuing them (without it, low address bits are ignored).
module memory_access_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  load_memory_i,
  input  logic                  store_memory_i,
  input  logic [2:0]            funct3_memory_i,
  input  logic [DATA_WIDTH-1:0] ALU_result_memory_i,
  input  logic [DATA_WIDTH-1:0] store_data_memory_i,
  memory_access_unit_if.master  dmem,
  output logic [DATA_WIDTH-1:0] load_data_memory_o,
  output logic                  memory_stall_o,
  output logic                  misaligned_access_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RESP,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] loadData_q, loadData_d;
  logic                  misaligned_q, misaligned_d;

  logic                  access;
  logic                  isStore;
  logic [1:0]            byteOff;
  logic                  isWord;
  logic                  isHalf;
  logic                  misalignedReq;
  logic                  capture;
  logic [3:0]            storeByteEn;
  logic [DATA_WIDTH-1:0] storeWdata;
  logic [4:0]            loadShamt;
  logic [DATA_WIDTH-1:0] loadShifted;
  logic [DATA_WIDTH-1:0] loadAligned;
  logic                  unused_addr_bits;

  // A simultaneous load and store is handled as a load.
  assign access  = load_memory_i | store_memory_i;
  assign isStore = store_memory_i & ~load_memory_i;
  assign byteOff = ALU_result_memory_i[1:0];
  assign isWord  = funct3_memory_i[1];
  assign isHalf  = (funct3_memory_i[1:0] == 2'b01);

  assign unused_addr_bits = ^ALU_result_memory_i[DATA_WIDTH-1:ADDRESS_BITS+2];

`ifdef MISALIGN_TRAP_EN
  assign misalignedReq = access & ((isHalf & byteOff[0]) | (isWord & (byteOff != 2'b00)));
`else
  assign misalignedReq = 1'b0;
`endif

  // Store lane placement: replicate the low bits and enable only the addressed lanes.
  always_comb begin
    storeByteEn = 4'hF;
    storeWdata  = store_data_memory_i;
    if (isWord) begin
      storeByteEn = 4'hF;
      storeWdata  = store_data_memory_i;
    end else if (isHalf) begin
      storeByteEn = 4'b0011 << {byteOff[1], 1'b0};
      storeWdata  = {2{store_data_memory_i[15:0]}};
    end else begin
      storeByteEn = 4'b0001 << byteOff;
      storeWdata  = {4{store_data_memory_i[7:0]}};
    end
  end

  assign dmem.dmem_we      = isStore;
  assign dmem.dmem_byte_en = isStore ? storeByteEn : 4'hF;
  assign dmem.dmem_address = ALU_result_memory_i[ADDRESS_BITS+1:2];
  assign dmem.dmem_wdata   = storeWdata;

  // Load alignment: shift the addressed byte/halfword down, then zero- or sign-extend.
  always_comb begin
    loadShamt   = 5'd0;
    loadAligned = '0;
    if (isWord) begin
      loadShamt = 5'd0;
    end else if (isHalf) begin
      loadShamt = {byteOff[1], 4'b0000};
    end else begin
      loadShamt = {byteOff, 3'b000};
    end
    loadShifted = dmem.dmem_rdata >> loadShamt;
    if (isWord) begin
      loadAligned = loadShifted;
    end else if (isHalf) begin
      loadAligned = funct3_memory_i[2] ? {{(DATA_WIDTH-16){1'b0}}, loadShifted[15:0]}
                                       : {{(DATA_WIDTH-16){loadShifted[15]}}, loadShifted[15:0]};
    end else begin
      loadAligned = funct3_memory_i[2] ? {{(DATA_WIDTH-8){1'b0}}, loadShifted[7:0]}
                                       : {{(DATA_WIDTH-8){loadShifted[7]}}, loadShifted[7:0]};
    end
  end

  // Next-state and handshake outputs; the stall drops only in DONE so the pipeline advances once.
  always_comb begin
    state_d             = state_q;
    dmem.dmem_req_valid = 1'b0;
    memory_stall_o      = 1'b0;
    capture             = 1'b0;
    misaligned_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (misalignedReq) begin
          memory_stall_o = 1'b1;
          misaligned_d   = 1'b1;
          state_d        = DONE;
        end else if (access) begin
          dmem.dmem_req_valid = 1'b1;
          memory_stall_o      = 1'b1;
          if (dmem.dmem_req_ready) begin
            state_d = isStore ? DONE : WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        memory_stall_o = 1'b1;
        if (dmem.dmem_resp_valid) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign loadData_d = capture ? loadAligned : loadData_q;

  // State, captured load data and the one-cycle misalignment flag.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      loadData_q   <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      loadData_q   <= loadData_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign load_data_memory_o  = loadData_q;
  assign misaligned_access_o = misaligned_q;

endmodule
